// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the Sasanqua fetch front end and decode stages.
package inst_fetch_queue_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: MMU instruction read port, redirect inputs and decode-side outputs.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic              FLUSH;
  logic [INST_W-1:0] NEW_PC;
  logic              STALL;
  logic              MEM_WAIT;
  logic              INST_RDEN;
  logic [INST_W-1:0] INST_RIADDR;
  logic              INST_RVALID;
  logic [INST_W-1:0] INST_ROADDR;
  logic [INST_W-1:0] INST_RDATA;
  logic              INST_VALID;
  logic [INST_W-1:0] INST_PC;
  logic [INST_W-1:0] INST_DATA;

  // The fetch queue itself.
  modport master (
    input  FLUSH, NEW_PC, STALL, MEM_WAIT,
    input  INST_RVALID, INST_ROADDR, INST_RDATA,
    output INST_RDEN, INST_RIADDR,
    output INST_VALID, INST_PC, INST_DATA
  );

  // The surrounding MMU / decode / jump-resolution logic.
  modport slave (
    output FLUSH, NEW_PC, STALL, MEM_WAIT,
    output INST_RVALID, INST_ROADDR, INST_RDATA,
    input  INST_RDEN, INST_RIADDR,
    input  INST_VALID, INST_PC, INST_DATA
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Small FIFO of {pc, inst} pairs; the head entry and its valid flag are registered.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t pushEntry_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o,
  output logic         headValid_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          headValid_q, headValid_d;
  fetch_entry_t  head_q, head_d;
  logic          doPush, doPop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign headValid_o = headValid_q;
  assign head_o      = head_q;

  // Next pointers/count, and the entry that will sit at the head next cycle
  // (bypassing the push data when it lands directly in the head slot).
  always_comb begin
    doPop       = pop_i && !empty_o && !clear_i;
    doPush      = push_i && !clear_i && (!full_o || doPop);
    rdPtr_d     = doPop ? rdPtr_q + AW'(1) : rdPtr_q;
    wrPtr_d     = doPush ? wrPtr_q + AW'(1) : wrPtr_q;
    count_d     = count_q + CW'(doPush) - CW'(doPop);
    headValid_d = headValid_q;
    head_d      = head_q;
    if (clear_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end
    if (count_d == '0) begin
      headValid_d = 1'b0;
    end else begin
      headValid_d = 1'b1;
      head_d      = (doPush && (wrPtr_q == rdPtr_d)) ? pushEntry_i : mem_q[rdPtr_d];
    end
  end

  // Storage array has no reset; only slots below count are ever observed.
  always_ff @(posedge CLK) begin
    if (doPush) mem_q[wrPtr_q] <= pushEntry_i;
  end

  // Pointer, count and head-register state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      headValid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      headValid_q <= headValid_d;
      head_q      <= head_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential fetch, response buffering,
// and redirect handling that drops responses still in flight at a FLUSH.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                CLK,
  input logic                RST,
  inst_fetch_queue_if.master fq
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] fetchPc_q, fetchPc_d;
  logic [INST_W-1:0] riaddr_q, riaddr_d;
  logic              rden_q, rden_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW:0]       committed;
  logic              credit, issue, keepResp, popHead, fifoClear;

  logic              fifoFull, fifoEmpty, fifoHeadValid;
  logic [CW-1:0]     fifoCount;
  fetch_entry_t      fifoHead, respEntry;

  assign respEntry = '{pc: fq.INST_ROADDR, inst: fq.INST_RDATA};

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .clear_i     (fifoClear),
    .push_i      (keepResp),
    .pushEntry_i (respEntry),
    .pop_i       (popHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .count_o     (fifoCount),
    .headValid_o (fifoHeadValid),
    .head_o      (fifoHead)
  );

  assign fq.INST_RDEN   = rden_q;
  assign fq.INST_RIADDR = riaddr_q;
  assign fq.INST_VALID  = fifoHeadValid;
  assign fq.INST_PC     = fifoHead.pc;
  assign fq.INST_DATA   = fifoHead.inst;

  // Issue/credit/discard decisions; FLUSH overrides everything else in its cycle.
  always_comb begin
    state_d    = state_q;
    fetchPc_d  = fetchPc_q;
    riaddr_d   = riaddr_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rden_d     = 1'b0;
    issue      = 1'b0;
    keepResp   = 1'b0;
    popHead    = 1'b0;
    fifoClear  = 1'b0;
    committed  = {1'b0, inflight_q} + {1'b0, fifoCount};
    credit     = (committed < DEPTH_C);
    if (fq.FLUSH) begin
      fifoClear  = 1'b1;
      fetchPc_d  = fq.NEW_PC;
      inflight_d = inflight_q - CW'(fq.INST_RVALID);
      discard_d  = inflight_d;
      state_d    = (inflight_d != '0) ? DRAIN : RUN;
    end else begin
      issue      = !fq.MEM_WAIT && credit && !fifoFull;
      popHead    = !fifoEmpty && !fq.STALL;
      keepResp   = fq.INST_RVALID && (state_q == RUN);
      inflight_d = inflight_q + CW'(issue) - CW'(fq.INST_RVALID);
      if (fq.INST_RVALID && (state_q == DRAIN)) begin
        discard_d = discard_q - CW'(1);
        if (discard_d == '0) state_d = RUN;
      end
      if (issue) begin
        rden_d    = 1'b1;
        riaddr_d  = fetchPc_q;
        fetchPc_d = fetchPc_q + PC_STEP;
      end
    end
  end

  // Registered control state and request outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= RUN;
      fetchPc_q  <= RESET_PC;
      riaddr_q   <= RESET_PC;
      rden_q     <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetchPc_q  <= fetchPc_d;
      riaddr_q   <= riaddr_d;
      rden_q     <= rden_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: an in-order MMU with variable latency,
// and a reference model of the delivered instruction stream built from queues.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  logic CLK = 1'b0;
  logic RST;

  inst_fetch_queue_if fqIf ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK (CLK),
    .RST (RST),
    .fq  (fqIf)
  );

  always #5 CLK = ~CLK;

  req_t        memQ[$];
  logic [31:0] modelQ[$];
  logic [31:0] expReq;
  int          cyc, latency, passCnt, checkCnt, popCnt, rdenCnt;
  bit          prevMemWait, prevFlush, obsRden, obsValid;
  logic [31:0] obsPc, obsAddr;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic clearModel();
    memQ.delete();
    modelQ.delete();
    expReq                = RESET_PC;
    prevMemWait           = 1'b0;
    prevFlush             = 1'b0;
    fqIf.FLUSH            = 1'b0;
    fqIf.NEW_PC           = '0;
    fqIf.STALL            = 1'b0;
    fqIf.MEM_WAIT         = 1'b0;
    fqIf.INST_RVALID      = 1'b0;
    fqIf.INST_ROADDR      = '0;
    fqIf.INST_RDATA       = '0;
  endtask

  task automatic doReset();
    RST = 1'b0;
    clearModel();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Sample registered outputs just after the edge and compare with the model.
  task automatic stepObserve();
    @(posedge CLK);
    #1;
    cyc++;
    obsRden  = (fqIf.INST_RDEN === 1'b1);
    obsValid = (fqIf.INST_VALID === 1'b1);
    obsPc    = fqIf.INST_PC;
    obsAddr  = fqIf.INST_RIADDR;
    checkCnt++;
    if (fqIf.INST_VALID !== (modelQ.size() != 0))
      $display("[TB] FAIL inst_valid cyc=%0d got %b want %b", cyc, fqIf.INST_VALID, modelQ.size() != 0);
    else passCnt++;
    if (obsValid && modelQ.size() != 0) begin
      checkCnt++;
      if (fqIf.INST_PC !== modelQ[0])
        $display("[TB] FAIL head_pc cyc=%0d got %h want %h", cyc, fqIf.INST_PC, modelQ[0]);
      else passCnt++;
      checkCnt++;
      if (fqIf.INST_DATA !== memWord(modelQ[0]))
        $display("[TB] FAIL head_data cyc=%0d got %h want %h", cyc, fqIf.INST_DATA, memWord(modelQ[0]));
      else passCnt++;
    end
    if (obsRden) begin
      checkCnt++;
      if (prevMemWait || prevFlush)
        $display("[TB] FAIL rden_blocked cyc=%0d got 1 want 0", cyc);
      else passCnt++;
      checkCnt++;
      if (fqIf.INST_RIADDR !== expReq)
        $display("[TB] FAIL req_addr cyc=%0d got %h want %h", cyc, fqIf.INST_RIADDR, expReq);
      else passCnt++;
      expReq = expReq + 32'd4;
      rdenCnt++;
      memQ.push_back('{addr: fqIf.INST_RIADDR, due: cyc + latency, stale: 1'b0});
    end
    checkCnt++;
    if (memQ.size() + modelQ.size() > DEPTH)
      $display("[TB] FAIL credit cyc=%0d got %0d want <=%0d", cyc, memQ.size() + modelQ.size(), DEPTH);
    else passCnt++;
  endtask

  // Drive this cycle's inputs and advance the model by what the edge will do.
  task automatic stepDrive(input bit stall, input bit mw, input bit flush,
                           input logic [31:0] newPc, input bit respEn);
    req_t r;
    fqIf.STALL       = stall;
    fqIf.MEM_WAIT    = mw;
    fqIf.FLUSH       = flush;
    fqIf.NEW_PC      = newPc;
    fqIf.INST_RVALID = 1'b0;
    fqIf.INST_ROADDR = $urandom();
    fqIf.INST_RDATA  = $urandom();
    if (!flush && !stall && modelQ.size() != 0) begin
      void'(modelQ.pop_front());
      popCnt++;
    end
    if (respEn && memQ.size() != 0 && memQ[0].due <= cyc) begin
      r = memQ.pop_front();
      fqIf.INST_RVALID = 1'b1;
      fqIf.INST_ROADDR = r.addr;
      fqIf.INST_RDATA  = memWord(r.addr);
      if (!r.stale && !flush) modelQ.push_back(r.addr);
    end
    if (flush) begin
      modelQ.delete();
      foreach (memQ[i]) memQ[i].stale = 1'b1;
      expReq = newPc;
    end
    prevMemWait = mw;
    prevFlush   = flush;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    clearModel();
    #12;
    checkCnt++;
    if (fqIf.INST_RDEN !== 1'b0) $display("[TB] FAIL reset_rden got %b want 0", fqIf.INST_RDEN); else passCnt++;
    checkCnt++;
    if (fqIf.INST_RIADDR !== RESET_PC) $display("[TB] FAIL reset_riaddr got %h want %h", fqIf.INST_RIADDR, RESET_PC); else passCnt++;
    checkCnt++;
    if (fqIf.INST_VALID !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", fqIf.INST_VALID); else passCnt++;
    checkCnt++;
    if (fqIf.INST_PC !== 32'h0) $display("[TB] FAIL reset_pc got %h want 0", fqIf.INST_PC); else passCnt++;
    checkCnt++;
    if (fqIf.INST_DATA !== 32'h0) $display("[TB] FAIL reset_data got %h want 0", fqIf.INST_DATA); else passCnt++;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_stream();
    int firstRden, firstValid, gaps;
    logic [31:0] firstPc;
    firstRden = -1; firstValid = -1; gaps = 0; firstPc = 'x;
    latency = 1;
    for (int i = 0; i < 20; i++) begin
      stepObserve();
      if (obsRden && firstRden < 0) firstRden = i;
      if (obsValid && firstValid < 0) begin firstValid = i; firstPc = obsPc; end
      else if (firstValid >= 0 && !obsValid) gaps++;
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (firstRden != 0) $display("[TB] FAIL first_rden got %0d want 0", firstRden); else passCnt++;
    checkCnt++;
    if (firstValid - firstRden != 2) $display("[TB] FAIL first_latency got %0d want 2", firstValid - firstRden); else passCnt++;
    checkCnt++;
    if (firstPc !== RESET_PC) $display("[TB] FAIL first_pc got %h want %h", firstPc, RESET_PC); else passCnt++;
    checkCnt++;
    if (gaps != 0) $display("[TB] FAIL throughput_gaps got %0d want 0", gaps); else passCnt++;
  endtask

  task automatic test_stall();
    int lateRden, startPop;
    lateRden = 0;
    for (int i = 0; i < 10; i++) begin
      stepObserve();
      if (i >= 5 && obsRden) lateRden++;
      stepDrive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (lateRden != 0) $display("[TB] FAIL stall_rden_stop got %0d want 0", lateRden); else passCnt++;
    checkCnt++;
    if (modelQ.size() != DEPTH) $display("[TB] FAIL stall_fill got %0d want %0d", modelQ.size(), DEPTH); else passCnt++;
    startPop = popCnt;
    for (int i = 0; i < 15; i++) begin
      stepObserve();
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (popCnt - startPop < 12) $display("[TB] FAIL stall_resume got %0d want >=12", popCnt - startPop); else passCnt++;
  endtask

  task automatic test_memwait();
    int winRden, startRden;
    winRden = 0;
    for (int i = 0; i < 5; i++) begin
      stepObserve();
      if (prevMemWait && obsRden) winRden++;
      stepDrive(1'b0, 1'b1, 1'b0, '0, 1'b1);
    end
    stepObserve();
    if (prevMemWait && obsRden) winRden++;
    stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkCnt++;
    if (winRden != 0) $display("[TB] FAIL memwait_rden got %0d want 0", winRden); else passCnt++;
    startRden = rdenCnt;
    for (int i = 0; i < 10; i++) begin
      stepObserve();
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (rdenCnt - startRden < 8) $display("[TB] FAIL memwait_resume got %0d want >=8", rdenCnt - startRden); else passCnt++;
  endtask

  task automatic test_flush();
    bit found, gotFirst;
    int staleSeen;
    logic [31:0] firstPc;
    found = 0; gotFirst = 0; staleSeen = 0; firstPc = '0;
    doReset();
    latency = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      stepObserve();
      if (memQ.size() == 3) begin
        found = 1;
        stepDrive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
      end else stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (!found) $display("[TB] FAIL flush_setup got 0 want 1"); else passCnt++;
    for (int i = 0; i < 20; i++) begin
      stepObserve();
      if (obsValid) begin
        if (!gotFirst) begin gotFirst = 1; firstPc = obsPc; end
        if (obsPc < 32'h100) staleSeen++;
      end
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (!gotFirst || firstPc !== 32'h100) $display("[TB] FAIL flush_first_pc got %h want 00000100", firstPc); else passCnt++;
    checkCnt++;
    if (staleSeen != 0) $display("[TB] FAIL flush_stale got %0d want 0", staleSeen); else passCnt++;
  endtask

  task automatic test_flush_collide();
    bit found, gotFirst;
    int staleSeen;
    logic [31:0] firstPc;
    found = 0; gotFirst = 0; staleSeen = 0; firstPc = '0;
    doReset();
    latency = 3;
    for (int i = 0; i < 30 && !found; i++) begin
      stepObserve();
      if (obsValid && memQ.size() >= 2 && memQ[0].due <= cyc) begin
        found = 1;
        stepDrive(1'b0, 1'b0, 1'b1, 32'h180, 1'b1);
      end else stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (!found) $display("[TB] FAIL collide_setup got 0 want 1"); else passCnt++;
    stepObserve();
    stepDrive(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 25; i++) begin
      stepObserve();
      if (obsValid) begin
        if (!gotFirst) begin gotFirst = 1; firstPc = obsPc; end
        if (obsPc < 32'h200) staleSeen++;
      end
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (!gotFirst || firstPc !== 32'h200) $display("[TB] FAIL collide_first_pc got %h want 00000200", firstPc); else passCnt++;
    checkCnt++;
    if (staleSeen != 0) $display("[TB] FAIL collide_stale got %0d want 0", staleSeen); else passCnt++;
  endtask

  task automatic test_random();
    int startPop;
    bit fl;
    startPop = popCnt;
    for (int i = 0; i < 400; i++) begin
      latency = $urandom_range(1, 4);
      stepObserve();
      fl = ($urandom_range(0, 99) < 3);
      stepDrive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20, fl,
                $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 99) < 80);
    end
    checkCnt++;
    if (popCnt - startPop < 40) $display("[TB] FAIL random_progress got %0d want >=40", popCnt - startPop); else passCnt++;
  endtask

  task automatic test_wrap();
    bit sawTop, sawWrap;
    sawTop = 0; sawWrap = 0;
    latency = 1;
    stepObserve();
    stepDrive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 15; i++) begin
      stepObserve();
      if (obsValid && obsPc === 32'hFFFF_FFFC) sawTop = 1;
      if (obsValid && sawTop && obsPc === 32'h0) sawWrap = 1;
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (!sawWrap) $display("[TB] FAIL pc_wrap got 0 want 1"); else passCnt++;
  endtask

  task automatic test_reset_mid();
    bit found;
    logic [31:0] firstAddr;
    found = 0; firstAddr = 'x;
    latency = 2;
    for (int i = 0; i < 8; i++) begin
      stepObserve();
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    #3;
    RST = 1'b0;
    #1;
    checkCnt++;
    if (fqIf.INST_RDEN !== 1'b0) $display("[TB] FAIL midrst_rden got %b want 0", fqIf.INST_RDEN); else passCnt++;
    checkCnt++;
    if (fqIf.INST_RIADDR !== RESET_PC) $display("[TB] FAIL midrst_riaddr got %h want %h", fqIf.INST_RIADDR, RESET_PC); else passCnt++;
    checkCnt++;
    if (fqIf.INST_VALID !== 1'b0) $display("[TB] FAIL midrst_valid got %b want 0", fqIf.INST_VALID); else passCnt++;
    checkCnt++;
    if (fqIf.INST_PC !== 32'h0) $display("[TB] FAIL midrst_pc got %h want 0", fqIf.INST_PC); else passCnt++;
    checkCnt++;
    if (fqIf.INST_DATA !== 32'h0) $display("[TB] FAIL midrst_data got %h want 0", fqIf.INST_DATA); else passCnt++;
    clearModel();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6 && !found; i++) begin
      stepObserve();
      if (obsRden) begin found = 1; firstAddr = obsAddr; end
      stepDrive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkCnt++;
    if (!found || firstAddr !== RESET_PC) $display("[TB] FAIL restart_addr got %h want %h", firstAddr, RESET_PC); else passCnt++;
  endtask

  // Scenario sequence.
  initial begin
    cyc = 0; latency = 1; passCnt = 0; checkCnt = 0; popCnt = 0; rdenCnt = 0;
    test_reset();
    test_stream();
    test_stall();
    test_memwait();
    test_flush();
    test_flush_collide();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
